// File: rtl/ysyx_2022040010_scoreboard.sv
// rtl/ysyx_2022040010_scoreboard.sv - register scoreboard and MDU stall controller
//
// Tracks registers with an outstanding long-latency write (loads, MDU ops),
// detects RAW/WAW hazards for the ID-stage instruction, holds the pipeline
// while a multi-cycle MDU operation runs, and counts stalled cycles.
//
// Ports:
//   clk                      clock, all state updates on posedge
//   rst                      synchronous active-low reset
//   id_valid/id_re1/id_re2   ID-stage valid and source-read enables
//   id_we/id_long            ID-stage rd write enable and long-latency flag
//   id_rs1/id_rs2/id_rd      ID-stage register addresses
//   wb_we/wb_long/wb_waddr   WB-stage write enable, long-op completion, rd
//   mdu_start/mdu_done       MDU launch and completion pulses
//   flush                    kills the ID-stage instruction this cycle
//   stall                    pipeline hold vector (bit0=PC .. bit5=WB)
//   issue_ok                 ID instruction accepted this cycle
//   pending                  per-register outstanding long write
//   stall_cnt                saturating count of stalled cycles
module ysyx_2022040010_scoreboard #(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_re1,
  input  logic               id_re2,
  input  logic               id_we,
  input  logic               id_long,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               wb_we,
  input  logic               wb_long,
  input  logic [4:0]         wb_waddr,
  input  logic               mdu_start,
  input  logic               mdu_done,
  input  logic               flush,
  output logic [STALL_W-1:0] stall,
  output logic               issue_ok,
  output logic [31:0]        pending,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // MDU hold freezes PC..EX; a data hazard freezes PC..ID only.
  localparam logic [STALL_W-1:0] STALL_MDU = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_HAZ = STALL_W'(6'b000111);

  state_t             r_state;
  logic [31:0]        r_pending;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_clr;
  logic [31:0]        w_clr_mask;
  logic [31:0]        w_set_mask;
  logic [31:0]        w_pend_eff;
  logic [31:0]        w_pending_nxt;
  logic               w_raw1;
  logic               w_raw2;
  logic               w_waw;
  logic               w_hazard;
  logic               w_mdu_hold;
  logic [STALL_W-1:0] w_stall;
  logic               w_issue_ok;

  assign w_clr      = wb_we & wb_long & (wb_waddr != 5'd0);
  assign w_clr_mask = w_clr ? (32'd1 << wb_waddr) : 32'd0;

  // A register being released this cycle reads as free: the regfile
  // forwards the WB data to a same-cycle read.
  assign w_pend_eff = r_pending & ~w_clr_mask;

  assign w_raw1   = id_re1 & (id_rs1 != 5'd0) & w_pend_eff[id_rs1];
  assign w_raw2   = id_re2 & (id_rs2 != 5'd0) & w_pend_eff[id_rs2];
  assign w_waw    = id_we  & (id_rd  != 5'd0) & w_pend_eff[id_rd];
  assign w_hazard = id_valid & ~flush & (w_raw1 | w_raw2 | w_waw);

  assign w_mdu_hold = (mdu_start | (r_state == S_BUSY)) & ~mdu_done;

  always_comb begin
    w_stall = '0;
    if (!rst)            w_stall = '0;
    else if (w_mdu_hold) w_stall = STALL_MDU;
    else if (w_hazard)   w_stall = STALL_HAZ;
  end

  assign w_issue_ok = rst & id_valid & ~flush & ~w_hazard & ~w_mdu_hold;

  assign w_set_mask = (w_issue_ok & id_we & id_long & (id_rd != 5'd0))
                      ? (32'd1 << id_rd) : 32'd0;

  // Set is applied after clear so a same-cycle reissue keeps the bit pending.
  assign w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pending   <= 32'd0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (mdu_start & ~mdu_done) r_state <= S_BUSY;
        S_BUSY:  if (mdu_done)              r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      r_pending <= w_pending_nxt;
      if ((w_stall != '0) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall     = w_stall;
  assign issue_ok  = w_issue_ok;
  assign pending   = r_pending;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ysyx_2022040010_scoreboard.sv
// tb/tb_ysyx_2022040010_scoreboard.sv - directed self-checking bench for the scoreboard
module tb_ysyx_2022040010_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid, id_re1, id_re2, id_we, id_long;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        wb_we, wb_long;
  logic [4:0]  wb_waddr;
  logic        mdu_start, mdu_done, flush;
  logic [5:0]  stall, s_stall;
  logic        issue_ok, s_issue_ok;
  logic [31:0] pending, s_pending;
  logic [31:0] stall_cnt;
  logic [3:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_2022040010_scoreboard #(.STALL_W(6), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_re1(id_re1), .id_re2(id_re2), .id_we(id_we), .id_long(id_long),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .wb_we(wb_we), .wb_long(wb_long), .wb_waddr(wb_waddr),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .flush(flush),
    .stall(stall), .issue_ok(issue_ok), .pending(pending), .stall_cnt(stall_cnt)
  );

  ysyx_2022040010_scoreboard #(.STALL_W(6), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_re1(id_re1), .id_re2(id_re2), .id_we(id_we), .id_long(id_long),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .wb_we(wb_we), .wb_long(wb_long), .wb_waddr(wb_waddr),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .flush(flush),
    .stall(s_stall), .issue_ok(s_issue_ok), .pending(s_pending), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_re1 = 0; id_re2 = 0; id_we = 0; id_long = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    wb_we = 0; wb_long = 0; wb_waddr = 0;
    mdu_start = 0; mdu_done = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle_inputs();
    id_valid = 1; id_we = 1; id_long = 1; id_rd = rd;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    id_valid = 1; mdu_start = 1;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL reset_stall_comb got %h exp %h", stall, 6'h00); end
    n_cmp++; if (issue_ok !== 1'b0) begin n_bad++; $display("FAIL reset_issue_comb got %b exp %b", issue_ok, 1'b0); end
    step();
    step();
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL reset_pending got %h exp %h", pending, 32'h0); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp %0d", stall_cnt, 0); end
    idle_inputs();
    rst = 1;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL reset_idle_stall got %h exp %h", stall, 6'h00); end
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1; id_we = 1; id_long = 1; id_rd = 5;
    #1;
    n_cmp++; if (issue_ok !== 1'b1) begin n_bad++; $display("FAIL lu_issue got %b exp %b", issue_ok, 1'b1); end
    step();
    n_cmp++; if (pending !== 32'h20) begin n_bad++; $display("FAIL lu_pending got %h exp %h", pending, 32'h20); end
    idle_inputs();
    id_valid = 1; id_re1 = 1; id_rs1 = 5;
    #1;
    n_cmp++; if (stall !== 6'h07) begin n_bad++; $display("FAIL lu_stall got %h exp %h", stall, 6'h07); end
    n_cmp++; if (issue_ok !== 1'b0) begin n_bad++; $display("FAIL lu_blocked got %b exp %b", issue_ok, 1'b0); end
    step();
    wb_we = 1; wb_long = 1; wb_waddr = 5;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL lu_fwd_stall got %h exp %h", stall, 6'h00); end
    n_cmp++; if (issue_ok !== 1'b1) begin n_bad++; $display("FAIL lu_fwd_issue got %b exp %b", issue_ok, 1'b1); end
    step();
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL lu_released got %h exp %h", pending, 32'h0); end
    n_cmp++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, 1); end
  endtask

  task automatic test_rs2_waw();
    do_reset();
    issue_long(9);
    n_cmp++; if (pending !== 32'h200) begin n_bad++; $display("FAIL rw_pending got %h exp %h", pending, 32'h200); end
    id_valid = 1; id_re2 = 1; id_rs2 = 9;
    #1;
    n_cmp++; if (stall !== 6'h07) begin n_bad++; $display("FAIL rs2_stall got %h exp %h", stall, 6'h07); end
    idle_inputs();
    id_valid = 1; id_we = 1; id_rd = 9;
    #1;
    n_cmp++; if (stall !== 6'h07) begin n_bad++; $display("FAIL waw_stall got %h exp %h", stall, 6'h07); end
    idle_inputs();
    // a non-long WB write to x9 must not release it
    id_valid = 1; id_re1 = 1; id_rs1 = 9; wb_we = 1; wb_waddr = 9;
    #1;
    n_cmp++; if (issue_ok !== 1'b0) begin n_bad++; $display("FAIL short_wb_noclr got %b exp %b", issue_ok, 1'b0); end
    idle_inputs();
    // unrelated register reads freely
    id_valid = 1; id_re1 = 1; id_rs1 = 8; id_re2 = 1; id_rs2 = 10;
    #1;
    n_cmp++; if (issue_ok !== 1'b1) begin n_bad++; $display("FAIL indep_issue got %b exp %b", issue_ok, 1'b1); end
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    issue_long(0);
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL x0_pending got %h exp %h", pending, 32'h0); end
    id_valid = 1; id_re1 = 1; id_rs1 = 0;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL x0_stall got %h exp %h", stall, 6'h00); end
    n_cmp++; if (issue_ok !== 1'b1) begin n_bad++; $display("FAIL x0_issue got %b exp %b", issue_ok, 1'b1); end
    idle_inputs();
  endtask

  task automatic test_mdu();
    logic [5:0] exp_stall [0:4];
    exp_stall[0] = 6'h0F; exp_stall[1] = 6'h0F; exp_stall[2] = 6'h0F;
    exp_stall[3] = 6'h0F; exp_stall[4] = 6'h00;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      mdu_start = (c == 0 || c == 2);
      mdu_done  = (c == 4);
      id_valid  = 1;
      #1;
      n_cmp++; if (stall !== exp_stall[c]) begin n_bad++; $display("FAIL mdu_stall_c%0d got %h exp %h", c, stall, exp_stall[c]); end
      n_cmp++; if (issue_ok !== (c == 4)) begin n_bad++; $display("FAIL mdu_issue_c%0d got %b exp %b", c, issue_ok, (c == 4)); end
      step();
    end
    idle_inputs();
    #1;
    n_cmp++; if (stall_cnt !== 32'd4) begin n_bad++; $display("FAIL mdu_cnt got %0d exp %0d", stall_cnt, 4); end
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL mdu_idle got %h exp %h", stall, 6'h00); end
    // start and done together never leaves IDLE
    mdu_start = 1; mdu_done = 1;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL mdu_same_cycle got %h exp %h", stall, 6'h00); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL mdu_stays_idle got %h exp %h", stall, 6'h00); end
  endtask

  task automatic test_set_clr();
    do_reset();
    issue_long(7);
    id_valid = 1; id_we = 1; id_long = 1; id_rd = 7;
    wb_we = 1; wb_long = 1; wb_waddr = 7;
    #1;
    n_cmp++; if (issue_ok !== 1'b1) begin n_bad++; $display("FAIL setclr_issue got %b exp %b", issue_ok, 1'b1); end
    step();
    idle_inputs();
    n_cmp++; if (pending !== 32'h80) begin n_bad++; $display("FAIL setclr_pending got %h exp %h", pending, 32'h80); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_long(3);
    id_valid = 1; id_re1 = 1; id_rs1 = 3; id_we = 1; id_long = 1; id_rd = 4; flush = 1;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL flush_stall got %h exp %h", stall, 6'h00); end
    n_cmp++; if (issue_ok !== 1'b0) begin n_bad++; $display("FAIL flush_issue got %b exp %b", issue_ok, 1'b0); end
    step();
    idle_inputs();
    n_cmp++; if (pending !== 32'h08) begin n_bad++; $display("FAIL flush_pending got %h exp %h", pending, 32'h08); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    for (int r = 1; r < 16; r++) issue_long(5'(r));
    n_cmp++; if (pending !== 32'hFFFE) begin n_bad++; $display("FAIL rb_pending got %h exp %h", pending, 32'hFFFE); end
    mdu_start = 1;
    step();
    mdu_start = 0;
    #1;
    n_cmp++; if (stall !== 6'h0F) begin n_bad++; $display("FAIL rb_busy got %h exp %h", stall, 6'h0F); end
    rst = 0;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL rb_rst_stall got %h exp %h", stall, 6'h00); end
    step();
    rst = 1;
    #1;
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL rb_pending_clr got %h exp %h", pending, 32'h0); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rb_cnt got %0d exp %0d", stall_cnt, 0); end
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL rb_idle got %h exp %h", stall, 6'h00); end
    mdu_done = 1;
    step();
    mdu_done = 0;
    #1;
    n_cmp++; if (stall !== 6'h00) begin n_bad++; $display("FAIL rb_late_done got %h exp %h", stall, 6'h00); end
  endtask

  task automatic test_saturate();
    do_reset();
    mdu_start = 1;
    step();
    mdu_start = 0;
    repeat (19) step();
    n_cmp++; if (stall_cnt !== 32'd20) begin n_bad++; $display("FAIL sat_wide got %0d exp %0d", stall_cnt, 20); end
    n_cmp++; if (s_stall_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_narrow got %0d exp %0d", s_stall_cnt, 15); end
    mdu_done = 1;
    step();
    mdu_done = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_load_use();
    test_rs2_waw();
    test_x0();
    test_mdu();
    test_set_clr();
    test_flush();
    test_reset_busy();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_scoreboard.md
YSYX_2022040010_SCOREBOARD -- requirements
Module: ysyx_2022040010_scoreboard

Interface
REQ-001 SHALL have parameter STALL_W, default 6: stall vector width; bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB.
REQ-002 SHALL have parameter CNT_W, default 32: width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset; 0 at a posedge resets all state.
REQ-005 SHALL have ports id_valid/id_re1/id_re2/id_we/id_long  input  1 each  ID-stage valid, rs1 read, rs2 read, rd write and long-latency flag (load or MDU op).
REQ-006 SHALL have ports id_rs1/id_rs2/id_rd  input  5 each  ID-stage register addresses.
REQ-007 SHALL have ports wb_we/wb_long  input  1 each  WB-stage write enable and completing-long-op flag.
REQ-008 SHALL have port wb_waddr  input  5  WB-stage destination register, the same value driven to the regfile write port.
REQ-009 SHALL have ports mdu_start/mdu_done  input  1 each  multi-cycle MDU launch and completion pulses.
REQ-010 SHALL have port flush  input  1  kills the ID-stage instruction this cycle.
REQ-011 SHALL have ports stall  output  STALL_W  pipeline hold vector; issue_ok  output  1  ID instruction accepted this cycle.
REQ-012 SHALL have ports pending  output  32  per-register outstanding long write; stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-013 SHALL keep pending[0] at 0 always; x0 never becomes pending, never causes a hazard.
REQ-014 SHALL define clr = wb_we & wb_long & (wb_waddr != 0); clr releases pending[wb_waddr] at the next posedge.
REQ-015 SHALL flag RAW when id_re1 & rs1!=0 & pending[rs1], and clr does not target rs1; rs2 evaluated identically with id_re2.
REQ-016 SHALL flag WAW when id_we & rd!=0 & pending[rd], and clr does not target rd.
REQ-017 SHALL compute hazard = id_valid & ~flush & (RAW | WAW), combinationally, zero-cycle latency.
REQ-018 SHALL consider a register being released by clr in the same cycle as not pending, because the regfile forwards wdata on a same-cycle read.
REQ-019 SHALL run a 2-state MDU FSM: IDLE -> BUSY on mdu_start & ~mdu_done; BUSY -> IDLE on mdu_done; every other case holds the current state.
REQ-020 SHALL ignore mdu_start while in BUSY, with no state change.
REQ-021 SHALL compute mdu_hold = (mdu_start | state==BUSY) & ~mdu_done.
REQ-022 SHALL drive stall = 6'b001111 when mdu_hold; else 6'b000111 when hazard; else 0. mdu_hold takes priority.
REQ-023 SHALL drive issue_ok = id_valid & ~flush & ~hazard & ~mdu_hold.
REQ-024 SHALL set pending[id_rd] at the posedge when issue_ok & id_we & id_long & id_rd!=0.
REQ-025 SHALL give set priority over clr when both target the same register in one cycle; the register stays pending.
REQ-026 SHALL not alter pending or the FSM on flush; flush only suppresses the ID-stage hazard and issue.
REQ-027 SHALL increment stall_cnt by 1 at each posedge where stall != 0, saturating at all-ones with no wrap.

Reset
REQ-028 SHALL, at a posedge with rst=0, set the FSM to IDLE, pending=0 and stall_cnt=0, including mid-BUSY.
REQ-029 SHALL force stall=0 and issue_ok=0 combinationally while rst=0.
REQ-030 SHALL ignore a mdu_done arriving after reset aborted BUSY, since the FSM is in IDLE.

Verification
REQ-031 SHALL cover: issue load rd=5 (id_long=1) -> pending=0x20; next cycle ID reads rs1=5 -> stall=0x07, issue_ok=0; wb clr x5 -> same cycle stall=0, issue_ok=1.
REQ-032 SHALL cover: issue long rd=0 -> pending stays 0; later read rs1=0 -> no stall.
REQ-033 SHALL cover: mdu_start cycle 0, mdu_done cycle 4 -> stall=0x0F on cycles 0-3, 0 on cycle 4; stall_cnt=4; FSM IDLE afterwards.
REQ-034 SHALL cover: issue long rd=7 in the same cycle as clr of x7 -> pending[7]=1 after the edge.
REQ-035 SHALL cover: pending[3]=1, ID reads x3 with flush=1 -> stall=0, issue_ok=0, pending unchanged.
REQ-036 SHALL cover: rst=0 while BUSY with pending=0xFFFE -> next cycle pending=0, stall=0, stall_cnt=0; CNT_W=4 test saturates at 15.
